// File: rtl/calc_fine_latency_pkg.sv
// calc_fine_latency_pkg: shared state encoding and Q-format defaults for the fine latency calculator
package calc_fine_latency_pkg;
  typedef enum logic [2:0] {IDLE, DIV_M, DIV_S, CALC, DONE} state_e;
  localparam int QI = 16;
  localparam int QF = 8;
  localparam int QW = QI + QF;
  localparam logic [QW-1:0] TAP_7S_Q = 24'h004E00;
endpackage

// File: rtl/calc_fine_latency_mc_udiv_q_seq.sv
// udiv_q_seq: restoring divider, one quotient bit per cycle; done/quo flag the final step combinationally
module udiv_q_seq #(
  parameter int DW = 10,
  parameter int QI = 16,
  parameter int QF = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [QI+QF-1:0] num,
  input  logic [DW-1:0]    den,
  output logic             done,
  output logic [QI+QF-1:0] quo
);
  localparam int W = QI + QF;
  localparam int CW = $clog2(W + 1);
  logic [DW-1:0] rem_q, rem_d, den_q, den_d, rem_n;
  logic [W-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW:0] rem_sh;
  logic ge;
  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    ge = rem_sh >= {1'b0, den_q};
    rem_n = ge ? DW'(rem_sh - {1'b0, den_q}) : rem_sh[DW-1:0];
    quo = {quo_q[W-2:0], ge};
    done = cnt_q == CW'(1);
    rem_d = start ? '0 : cnt_q != '0 ? rem_n : rem_q;
    quo_d = start ? num : cnt_q != '0 ? quo : quo_q;
    den_d = start ? den : den_q;
    cnt_d = start ? CW'(W) : cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      den_q <= den_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/calc_fine_latency_mc.sv
// calc_fine_latency_mc: per-channel fine latency in ps from IDELAY calibration counts and serdes latency
module calc_fine_latency_mc
  import calc_fine_latency_pkg::*;
#(
  parameter int kNumCh = 4,
  parameter int kCntBit = 9,
  parameter int kDelayPs = 1024,
  parameter int kAlignDelay = 54,
  parameter int kWidthTap = 5,
  parameter int kWidthSerdes = 4,
  parameter int kHalfPeriodPs = 1024,
  parameter int kWidthOut = 16,
  parameter int kQI = QI,
  parameter int kQF = QF,
  parameter logic [kQI+kQF-1:0] kTap7sQ = TAP_7S_Q
) (
  input  logic                           CLK,
  input  logic                           RSTn,
  input  logic                           start,
  input  logic [kCntBit-1:0]             cnt_master,
  input  logic [kCntBit-1:0]             cnt_slave,
  input  logic [kNumCh*kWidthTap-1:0]    idelay_tap,
  input  logic [kNumCh*kWidthSerdes-1:0] serdes_latency,
  output logic                           busy,
  output logic                           done,
  output logic [kNumCh*kWidthOut-1:0]    result,
  output logic                           result_valid,
  output logic                           err_div,
  output logic                           is_ultrascale
);
  localparam int W = kQI + kQF;
  localparam int DW = kCntBit + 1;
  localparam int CW = kNumCh > 1 ? $clog2(kNumCh) : 1;
  localparam int MW = kWidthTap + W;
  localparam logic [W-1:0] NUM = W'(kDelayPs * (2 ** kQF));
  state_e state_q, state_d;
  logic [kCntBit-1:0] cs_q, cs_d;
  logic [kNumCh*kWidthTap-1:0] tap_q, tap_d;
  logic [kNumCh*kWidthSerdes-1:0] sd_q, sd_d;
  logic [W-1:0] tap_m_q, tap_m_d, tap_sum_q, tap_sum_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [kNumCh*kWidthOut-1:0] result_q, result_d;
  logic bad_m_q, bad_m_d, rv_q, rv_d, err_q, err_d, us_q, us_d;
  logic [DW-1:0] div_m, den;
  logic div_start, div_done;
  logic [W-1:0] quo, tap_s;
  logic [W:0] sum;
  logic [kWidthTap-1:0] tap_c;
  logic signed [kWidthSerdes-1:0] sd_c;
  logic [MW-1:0] mul;
  logic signed [31:0] sd_ps;
  // divisor is two's complement in DW bits; the sign bit flags a negative master offset
  assign div_m = {1'b0, cnt_master} - DW'(kAlignDelay);
  assign div_start = (state_q == IDLE && start && cnt_master != '0) || (state_q == DIV_M && div_done);
  assign den = state_q == IDLE ? div_m : {1'b0, cs_q};
  udiv_q_seq #(.DW(DW), .QI(kQI), .QF(kQF)) u_div (
    .clk(CLK), .rst_n(RSTn), .start(div_start), .num(NUM), .den(den), .done(div_done), .quo(quo)
  );
  always_comb begin
    tap_s = cs_q == '0 ? '0 : quo;
    sum = {1'b0, tap_m_q} + {1'b0, tap_s};
    tap_c = tap_q[ch_q*kWidthTap +: kWidthTap];
    sd_c = sd_q[ch_q*kWidthSerdes +: kWidthSerdes];
    mul = MW'(tap_c) * MW'(tap_sum_q);
    sd_ps = 32'(sd_c) * 32'(kHalfPeriodPs);
    state_d = state_q;
    cs_d = cs_q;
    tap_d = tap_q;
    sd_d = sd_q;
    tap_m_d = tap_m_q;
    tap_sum_d = tap_sum_q;
    ch_d = ch_q;
    result_d = result_q;
    bad_m_d = bad_m_q;
    rv_d = rv_q;
    err_d = err_q;
    us_d = us_q;
    case (state_q)
      IDLE: if (start) begin
        us_d = cnt_master != '0;
        cs_d = cnt_slave;
        tap_d = idelay_tap;
        sd_d = serdes_latency;
        bad_m_d = div_m[DW-1] || div_m == '0;
        tap_sum_d = kTap7sQ;
        ch_d = '0;
        rv_d = 1'b0;
        err_d = 1'b0;
        state_d = cnt_master != '0 ? DIV_M : CALC;
      end
      DIV_M: if (div_done) begin
        tap_m_d = bad_m_q ? '0 : quo;
        err_d = bad_m_q;
        state_d = DIV_S;
      end
      DIV_S: if (div_done) begin
        tap_sum_d = sum[W] ? '1 : sum[W-1:0];
        err_d = err_q || cs_q == '0;
        state_d = CALC;
      end
      CALC: begin
        result_d[ch_q*kWidthOut +: kWidthOut] = kWidthOut'(32'(mul[MW-1:kQF]) + sd_ps);
        ch_d = ch_q + 1'b1;
        rv_d = ch_q == CW'(kNumCh - 1);
        state_d = ch_q == CW'(kNumCh - 1) ? DONE : CALC;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      state_q <= IDLE;
      cs_q <= '0;
      tap_q <= '0;
      sd_q <= '0;
      tap_m_q <= '0;
      tap_sum_q <= '0;
      ch_q <= '0;
      result_q <= '0;
      bad_m_q <= 1'b0;
      rv_q <= 1'b0;
      err_q <= 1'b0;
      us_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q <= cs_d;
      tap_q <= tap_d;
      sd_q <= sd_d;
      tap_m_q <= tap_m_d;
      tap_sum_q <= tap_sum_d;
      ch_q <= ch_d;
      result_q <= result_d;
      bad_m_q <= bad_m_d;
      rv_q <= rv_d;
      err_q <= err_d;
      us_q <= us_d;
    end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign result = result_q;
  assign result_valid = rv_q;
  assign err_div = err_q;
  assign is_ultrascale = us_q;
endmodule

// File: tb/tb_calc_fine_latency_mc.sv
// tb_calc_fine_latency_mc: directed vectors checked against a transaction-level model every cycle
module tb_calc_fine_latency_mc;
  localparam int NCH = 4;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [8:0] cnt_master = '0, cnt_slave = '0;
  logic [19:0] idelay_tap = '0;
  logic [15:0] serdes_latency = '0;
  logic busy, done, result_valid, err_div, is_ultrascale;
  logic [63:0] result;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  calc_fine_latency_mc dut (
    .CLK(clk), .RSTn(rst_n), .start(start), .cnt_master(cnt_master), .cnt_slave(cnt_slave),
    .idelay_tap(idelay_tap), .serdes_latency(serdes_latency), .busy(busy), .done(done),
    .result(result), .result_valid(result_valid), .err_div(err_div), .is_ultrascale(is_ultrascale)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] model_res(input int cm, input int cs, input logic [19:0] tp, input logic [15:0] sd);
    longint tsum, v;
    logic [63:0] r;
    logic [3:0] s4;
    r = '0;
    if (cm == 0) tsum = 78 * 256;
    else begin
      tsum = (cm - 54 > 0 ? (1024 * 256) / (cm - 54) : 0) + (cs != 0 ? (1024 * 256) / cs : 0);
      if (tsum > 2 ** 24 - 1) tsum = 2 ** 24 - 1;
    end
    for (int c = 0; c < NCH; c++) begin
      s4 = sd[c*4 +: 4];
      v = ((longint'(tp[c*5 +: 5]) * tsum) >> 8) + longint'($signed(s4)) * 1024;
      r[c*16 +: 16] = v[15:0];
    end
    return r;
  endfunction
  logic m_busy, m_rv, m_err, m_us, m_perr;
  logic [63:0] m_res, m_pres;
  int m_k, m_lat;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_busy <= 0; m_rv <= 0; m_err <= 0; m_us <= 0; m_perr <= 0;
      m_res <= '0; m_pres <= '0; m_k <= 0; m_lat <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1;
        m_k <= 0;
        m_us <= cnt_master != 0;
        m_rv <= 0;
        m_err <= 0;
        m_pres <= model_res(cnt_master, cnt_slave, idelay_tap, serdes_latency);
        m_perr <= cnt_master != 0 && (cnt_master <= 54 || cnt_slave == 0);
        m_lat <= cnt_master != 0 ? 2 * (16 + 8) + NCH + 1 : NCH + 1;
      end
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_lat - 1) begin
        m_rv <= 1;
        m_res <= m_pres;
        m_err <= m_perr;
      end
      if (m_k == m_lat - 1) m_busy <= 0;
    end
  always @(negedge clk) begin : cmp
    logic exp_done;
    exp_done = m_busy && m_k == m_lat - 1;
    chk("busy", busy, m_busy);
    chk("done", done, exp_done);
    chk("result_valid", result_valid, m_rv);
    chk("is_ultrascale", is_ultrascale, m_us);
    if (!m_busy || exp_done) begin
      chk("err_div", err_div, m_err);
      for (int c = 0; c < NCH; c++) chk("result_ch", result[c*16 +: 16], m_res[c*16 +: 16]);
    end
  end
  task automatic run(input int cm, input int cs, input logic [19:0] tp, input logic [15:0] sd, input bit rep, output int lat);
    int n, pulses;
    bit cont;
    @(negedge clk);
    cnt_master = 9'(cm);
    cnt_slave = 9'(cs);
    idelay_tap = tp;
    serdes_latency = sd;
    start = 1;
    n = 0; lat = 0; pulses = 0; cont = 1;
    while (n < 120 && !(lat != 0 && n >= lat + 3)) begin
      @(negedge clk);
      n++;
      start = rep && (n == 11 || n == 53);
      if (done) begin
        pulses++;
        if (lat == 0) lat = n;
      end
      if (lat == 0 && !busy) cont = 0;
    end
    start = 0;
    chk("done_seen", lat != 0, 1);
    chk("done_pulses", pulses, 1);
    chk("busy_continuous", cont, 1);
  endtask
  initial begin : main
    int lat;
    #1 rst_n = 0;
    start = 1;
    cnt_master = 9'd182;
    cnt_slave = 9'd128;
    repeat (3) @(negedge clk);
    start = 0;
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    chk("idle_after_rst", busy, 0);
    run(182, 128, {5'd0, 5'd31, 5'd10, 5'd3}, {4'h8, 4'h7, 4'h0, 4'hF}, 0, lat);
    chk("us_lat", lat, 53);
    chk("us_ch0", result[15:0], 16'hFC30);
    chk("us_ch2", result[47:32], 16'h1DF0);
    chk("us_ch3", result[63:48], 16'hE000);
    chk("us_err", err_div, 0);
    chk("us_mode", is_ultrascale, 1);
    run(0, 128, {5'd0, 5'd0, 5'd2, 5'd0}, {4'h0, 4'h0, 4'h1, 4'h0}, 0, lat);
    chk("s7_lat", lat, 5);
    chk("s7_ch1", result[31:16], 16'd1180);
    chk("s7_ch0", result[15:0], 16'd0);
    chk("s7_mode", is_ultrascale, 0);
    run(54, 128, {4{5'd4}}, {4{4'd2}}, 0, lat);
    chk("zdiv_err", err_div, 1);
    chk("zdiv_ch0", result[15:0], 16'd2080);
    chk("zdiv_ch3", result[63:48], 16'd2080);
    run(182, 0, {4{5'd4}}, {4{4'd2}}, 0, lat);
    chk("zslave_err", err_div, 1);
    chk("zslave_ch1", result[31:16], 16'd2080);
    run(40, 128, {4{5'd4}}, {4{4'd2}}, 0, lat);
    chk("negdiv_err", err_div, 1);
    run(182, 128, {5'd0, 5'd31, 5'd10, 5'd3}, {4'h8, 4'h7, 4'h0, 4'hF}, 1, lat);
    chk("repulse_lat", lat, 53);
    chk("repulse_ch0", result[15:0], 16'hFC30);
    @(negedge clk);
    cnt_master = 9'd182;
    cnt_slave = 9'd128;
    start = 1;
    @(negedge clk) start = 0;
    repeat (29) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    chk("arst_valid", result_valid, 0);
    chk("arst_err", err_div, 0);
    chk("arst_mode", is_ultrascale, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    run(182, 128, {5'd0, 5'd31, 5'd10, 5'd3}, {4'h8, 4'h7, 4'h0, 4'hF}, 0, lat);
    chk("post_rst_lat", lat, 53);
    run(55, 1, {4{5'd31}}, {4{4'd7}}, 0, lat);
    chk("wrap_lat", lat, 53);
    chk("wrap_ch0", result[15:0], 16'h1400);
    chk("wrap_ch3", result[63:48], 16'h1400);
    chk("wrap_err", err_div, 0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
